// File: rtl/mem_arbiter_if.sv
// Request/response and shared-memory signals of the fetch/load-store memory arbiter.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32
);
  logic                  if_valid;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic                  if_ready;
  logic [31:0]           if_rdata;

  logic                  ls_valid;
  logic                  ls_we;
  logic [ADDR_WIDTH-1:0] ls_addr;
  logic [31:0]           ls_wdata;
  logic [3:0]            ls_wstrb;
  logic                  ls_ready;
  logic [31:0]           ls_rdata;

  logic                  bus_err;

  logic                  mem_valid;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wstrb;
  logic                  mem_ready;
  logic [31:0]           mem_rdata;

  modport slave (
    input  if_valid, if_addr, ls_valid, ls_we, ls_addr, ls_wdata, ls_wstrb,
           mem_ready, mem_rdata,
    output if_ready, if_rdata, ls_ready, ls_rdata, bus_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );

  modport master (
    output if_valid, if_addr, ls_valid, ls_we, ls_addr, ls_wdata, ls_wstrb,
           mem_ready, mem_rdata,
    input  if_ready, if_rdata, ls_ready, ls_rdata, bus_err,
           mem_valid, mem_we, mem_addr, mem_wdata, mem_wstrb
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (fetch, load/store) arbiter onto one memory port with one
// outstanding transaction, round-robin on ties and a wait-cycle timeout.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input logic          clk,
  input logic          reset_n,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, MEM_IF, MEM_LS, RESP} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

  state_t                state_reg, state_next;
  logic                  last_ls_reg, last_ls_next;
  logic [7:0]            wait_cnt_reg, wait_cnt_next;

  logic                  grant_ls, grant_if, in_mem, mem_done, timed_out, finish, store;
  logic [31:0]           resp_data;

  logic                  mem_valid_next, mem_we_next;
  logic [ADDR_WIDTH-1:0] mem_addr_next;
  logic [31:0]           mem_wdata_next;
  logic [3:0]            mem_wstrb_next;
  logic                  if_ready_next, ls_ready_next, bus_err_next;
  logic [31:0]           if_rdata_next, ls_rdata_next;

  // LS wins unless both are requesting and LS had the previous grant.
  assign grant_ls  = bus.ls_valid && (!bus.if_valid || !last_ls_reg);
  assign grant_if  = bus.if_valid && !grant_ls;
  assign store     = grant_ls && bus.ls_we;
  assign in_mem    = (state_reg == MEM_IF) || (state_reg == MEM_LS);
  assign mem_done  = in_mem && bus.mem_ready;
  // A late mem_ready on the final wait cycle still completes normally.
  assign timed_out = in_mem && !bus.mem_ready && (wait_cnt_reg == TIMEOUT_LAST);
  assign finish    = mem_done || timed_out;
  assign resp_data = (mem_done && !bus.mem_we) ? bus.mem_rdata : 32'h0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= IDLE;
      last_ls_reg  <= 1'b0;
      wait_cnt_reg <= 8'd0;
    end else begin
      state_reg    <= state_next;
      last_ls_reg  <= last_ls_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    last_ls_next  = last_ls_reg;
    wait_cnt_next = wait_cnt_reg;
    case (state_reg)
      IDLE: begin
        wait_cnt_next = 8'd0;
        if (grant_ls) begin
          state_next   = MEM_LS;
          last_ls_next = 1'b1;
        end else if (grant_if) begin
          state_next   = MEM_IF;
          last_ls_next = 1'b0;
        end
      end
      MEM_IF, MEM_LS: begin
        if (finish) state_next = RESP;
        else        wait_cnt_next = wait_cnt_reg + 8'd1;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    mem_valid_next = bus.mem_valid;
    mem_we_next    = bus.mem_we;
    mem_addr_next  = bus.mem_addr;
    mem_wdata_next = bus.mem_wdata;
    mem_wstrb_next = bus.mem_wstrb;
    if_ready_next  = 1'b0;
    ls_ready_next  = 1'b0;
    bus_err_next   = 1'b0;
    if_rdata_next  = bus.if_rdata;
    ls_rdata_next  = bus.ls_rdata;
    case (state_reg)
      IDLE: begin
        if (grant_ls || grant_if) begin
          mem_valid_next = 1'b1;
          mem_we_next    = store;
          mem_addr_next  = grant_ls ? bus.ls_addr : bus.if_addr;
          mem_wdata_next = store ? bus.ls_wdata : 32'h0;
          mem_wstrb_next = store ? bus.ls_wstrb : 4'h0;
        end
      end
      MEM_IF, MEM_LS: begin
        if (finish) begin
          mem_valid_next = 1'b0;
          mem_we_next    = 1'b0;
          mem_addr_next  = '0;
          mem_wdata_next = 32'h0;
          mem_wstrb_next = 4'h0;
          bus_err_next   = timed_out;
          if (state_reg == MEM_IF) begin
            if_ready_next = 1'b1;
            if_rdata_next = resp_data;
          end else begin
            ls_ready_next = 1'b1;
            ls_rdata_next = resp_data;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bus.mem_valid <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= 32'h0;
      bus.mem_wstrb <= 4'h0;
      bus.if_ready  <= 1'b0;
      bus.ls_ready  <= 1'b0;
      bus.bus_err   <= 1'b0;
      bus.if_rdata  <= 32'h0;
      bus.ls_rdata  <= 32'h0;
    end else begin
      bus.mem_valid <= mem_valid_next;
      bus.mem_we    <= mem_we_next;
      bus.mem_addr  <= mem_addr_next;
      bus.mem_wdata <= mem_wdata_next;
      bus.mem_wstrb <= mem_wstrb_next;
      bus.if_ready  <= if_ready_next;
      bus.ls_ready  <= ls_ready_next;
      bus.bus_err   <= bus_err_next;
      bus.if_rdata  <= if_rdata_next;
      bus.ls_rdata  <= ls_rdata_next;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized bench for mem_arbiter: a transaction-level model predicts every
// output each cycle; directed scenarios pin the model with literal values.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int TO = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_WIDTH(AW)) bus();

  mem_arbiter #(.ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int txn_count = 0;

  // Model: one outstanding transaction, then one response cycle.
  bit          m_busy, m_resp, m_who, m_last_ls, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_wstrb;
  int          m_waited;
  bit          m_if_ready, m_ls_ready, m_err;
  logic [31:0] m_if_rdata, m_ls_rdata;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h required=%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_resp = 0; m_who = 0; m_last_ls = 0; m_we = 0;
    m_addr = 0; m_wdata = 0; m_wstrb = 0; m_waited = 0;
    m_if_ready = 0; m_ls_ready = 0; m_err = 0;
    m_if_rdata = 0; m_ls_rdata = 0;
  endtask

  task automatic model_step();
    logic [31:0] result;
    m_if_ready = 0; m_ls_ready = 0; m_err = 0;
    if (m_resp) begin
      m_resp = 0;
    end else if (m_busy) begin
      if (bus.mem_ready || (m_waited + 1 == TO)) begin
        result = (bus.mem_ready && !m_we) ? bus.mem_rdata : 32'h0;
        m_err  = !bus.mem_ready;
        if (m_who) begin m_ls_ready = 1; m_ls_rdata = result; end
        else       begin m_if_ready = 1; m_if_rdata = result; end
        m_busy = 0;
        m_resp = 1;
      end else begin
        m_waited++;
      end
    end else if (bus.if_valid || bus.ls_valid) begin
      m_who     = bus.ls_valid && !(bus.if_valid && m_last_ls);
      m_last_ls = m_who;
      m_we      = m_who && bus.ls_we;
      m_addr    = m_who ? bus.ls_addr : bus.if_addr;
      m_wdata   = m_we ? bus.ls_wdata : 32'h0;
      m_wstrb   = m_we ? bus.ls_wstrb : 4'h0;
      m_waited  = 0;
      m_busy    = 1;
    end
  endtask

  task automatic compare_all();
    chk("mem_valid", 32'(bus.mem_valid), 32'(m_busy));
    chk("mem_we",    32'(bus.mem_we),    32'(m_busy && m_we));
    chk("mem_addr",  bus.mem_addr,       m_busy ? m_addr : 32'h0);
    chk("mem_wstrb", 32'(bus.mem_wstrb), m_busy ? 32'(m_wstrb) : 32'h0);
    if (!m_busy || m_we) chk("mem_wdata", bus.mem_wdata, m_busy ? m_wdata : 32'h0);
    chk("if_ready",  32'(bus.if_ready),  32'(m_if_ready));
    chk("ls_ready",  32'(bus.ls_ready),  32'(m_ls_ready));
    chk("bus_err",   32'(bus.bus_err),   32'(m_err));
    chk("if_rdata",  bus.if_rdata,       m_if_rdata);
    chk("ls_rdata",  bus.ls_rdata,       m_ls_rdata);
    if (m_if_ready || m_ls_ready) begin
      txn_count++;
      $display("txn %0d %s rdata=%08h err=%0d t=%0t", txn_count, m_if_ready ? "IF" : "LS",
               m_if_ready ? bus.if_rdata : bus.ls_rdata, bus.bus_err, $time);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    compare_all();
  endtask

  // Asserted away from a clock edge; outputs must clear before any edge.
  task automatic apply_reset();
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all();
    chk("rst_mem_valid", 32'(bus.mem_valid), 32'h0);
    chk("rst_ls_ready",  32'(bus.ls_ready),  32'h0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    int held;
    int stall;
    bus.if_valid = 0; bus.if_addr = 0;
    bus.ls_valid = 0; bus.ls_we = 0; bus.ls_addr = 0; bus.ls_wdata = 0; bus.ls_wstrb = 0;
    bus.mem_ready = 0; bus.mem_rdata = 0;
    model_reset();
    #2;
    apply_reset();

    // Single fetch with memory always ready.
    bus.if_valid = 1; bus.if_addr = 32'h10; bus.mem_ready = 1; bus.mem_rdata = 32'h00500293;
    cycle();
    chk("t34_mem_valid", 32'(bus.mem_valid), 32'h1);
    chk("t34_mem_addr",  bus.mem_addr, 32'h10);
    chk("t34_mem_we",    32'(bus.mem_we), 32'h0);
    cycle();
    chk("t34_if_ready",  32'(bus.if_ready), 32'h1);
    chk("t34_if_rdata",  bus.if_rdata, 32'h00500293);
    bus.if_valid = 0;
    cycle();
    chk("t34_if_ready_pulse", 32'(bus.if_ready), 32'h0);

    // Tie after reset: LS first, then alternation.
    apply_reset();
    bus.if_valid = 1; bus.if_addr = 32'h40;
    bus.ls_valid = 1; bus.ls_we = 1; bus.ls_addr = 32'h20; bus.ls_wdata = 32'hDEADBEEF;
    bus.ls_wstrb = 4'hF; bus.mem_ready = 1; bus.mem_rdata = 32'h12345678;
    cycle();
    chk("t35_mem_we",    32'(bus.mem_we), 32'h1);
    chk("t35_mem_addr",  bus.mem_addr, 32'h20);
    chk("t35_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    chk("t35_mem_wstrb", 32'(bus.mem_wstrb), 32'hF);
    cycle();
    chk("t35_ls_ready",  32'(bus.ls_ready), 32'h1);
    chk("t35_ls_rdata",  bus.ls_rdata, 32'h0);
    cycle();
    cycle();
    chk("t35_if_grant",  bus.mem_addr, 32'h40);
    cycle();
    chk("t35_if_ready",  32'(bus.if_ready), 32'h1);
    chk("t35_if_rdata",  bus.if_rdata, 32'h12345678);
    cycle();
    cycle();
    chk("t35_ls_again",  bus.mem_addr, 32'h20);
    cycle();
    bus.if_valid = 0; bus.ls_valid = 0;
    cycle();

    // Load with mem_ready arriving on the last permitted wait cycle.
    bus.ls_valid = 1; bus.ls_we = 0; bus.ls_addr = 32'h80; bus.mem_ready = 0;
    bus.mem_rdata = 32'hCAFEF00D;
    cycle();
    held = 0;
    for (int i = 0; i < 6; i++) begin
      if (bus.mem_valid && bus.mem_addr == 32'h80) held++;
      if (i == 5) bus.mem_ready = 1;
      cycle();
    end
    chk("t36_held",     32'(held), 32'd6);
    chk("t36_ls_ready", 32'(bus.ls_ready), 32'h1);
    chk("t36_ls_rdata", bus.ls_rdata, 32'hCAFEF00D);
    chk("t36_bus_err",  32'(bus.bus_err), 32'h0);
    bus.ls_valid = 0;
    cycle();
    chk("t36_no_reissue", 32'(bus.mem_valid), 32'h0);
    cycle();
    chk("t30_ignored",  32'(bus.ls_ready), 32'h0);
    bus.mem_ready = 0;

    // Fetch that never gets mem_ready.
    bus.if_valid = 1; bus.if_addr = 32'h100;
    cycle();
    held = 0;
    for (int i = 0; i < 20 && !bus.if_ready; i++) begin
      if (bus.mem_valid) held++;
      cycle();
    end
    chk("t37_held",     32'(held), 32'd6);
    chk("t37_if_ready", 32'(bus.if_ready), 32'h1);
    chk("t37_bus_err",  32'(bus.bus_err), 32'h1);
    chk("t37_if_rdata", bus.if_rdata, 32'h0);
    bus.if_valid = 0;
    cycle();
    chk("t37_err_pulse", 32'(bus.bus_err), 32'h0);

    // Reset while a store is waiting on memory.
    bus.ls_valid = 1; bus.ls_we = 1; bus.ls_addr = 32'h200; bus.ls_wdata = 32'h55AA55AA;
    bus.ls_wstrb = 4'h3; bus.if_valid = 1; bus.if_addr = 32'h300;
    cycle();
    chk("t38_grant_ls", bus.mem_addr, 32'h200);
    cycle();
    apply_reset();
    cycle();
    chk("t38_regrant_ls", bus.mem_addr, 32'h200);
    chk("t38_regrant_we", 32'(bus.mem_we), 32'h1);

    // Random traffic with stalls, timeouts and one mid-run reset.
    stall = 0;
    for (int c = 0; c < 800; c++) begin
      if (m_if_ready || !bus.if_valid) begin
        bus.if_valid = ($urandom_range(0, 2) != 0);
        bus.if_addr  = $urandom & ~32'h3;
      end else if (m_busy && !m_who) begin
        bus.if_addr = $urandom;
      end
      if (m_ls_ready || !bus.ls_valid) begin
        bus.ls_valid = ($urandom_range(0, 2) != 0);
        bus.ls_we    = 1'($urandom_range(0, 1));
        bus.ls_addr  = $urandom & ~32'h3;
        bus.ls_wdata = $urandom;
        bus.ls_wstrb = 4'($urandom_range(1, 15));
      end else if (m_busy && m_who) begin
        bus.ls_addr  = $urandom;
        bus.ls_wdata = $urandom;
        bus.ls_wstrb = 4'($urandom);
        bus.ls_we    = 1'($urandom);
      end
      if (stall > 0) begin
        bus.mem_ready = 0;
        stall--;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.mem_ready = 0;
        stall = $urandom_range(3, 9);
      end else begin
        bus.mem_ready = ($urandom_range(0, 2) != 0);
      end
      bus.mem_rdata = $urandom;
      if (c == 400) apply_reset();
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
